// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: jump redirect/flush, ex-driven front-end hold and bounded bus tenure.
// Optional perf counters when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned BUS_MAX_HOLD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_req_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic [1:0]  hold_o,
  output logic        flush_o,
  output logic        bus_grant_o,
  output logic [1:0]  state_o
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] flush_cnt_o,
  output logic [31:0] bus_cnt_o
`endif
);

  localparam int unsigned FCNT_W = 3;
  localparam int unsigned BCNT_W = 8;
  localparam logic [FCNT_W-1:0] FCNT_LOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(BUS_MAX_HOLD - 1);
  localparam logic [1:0] HOLD_NONE = 2'd0;
  localparam logic [1:0] HOLD_ALL  = 2'd3;

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_FLUSH     = 2'd1,
    ST_BUS_HOLD  = 2'd2,
    ST_BUS_YIELD = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  logic [BCNT_W-1:0]   bcnt_q, bcnt_d;
  logic                grant_q;

  // State, counters and the registered bus grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RUN;
      fcnt_q  <= '0;
      bcnt_q  <= '0;
      grant_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
      bcnt_q  <= bcnt_d;
      grant_q <= (state_d == ST_BUS_HOLD);
    end
  end

  // Next state and same-cycle front-end controls
  always_comb begin
    state_d     = state_q;
    fcnt_d      = fcnt_q;
    bcnt_d      = bcnt_q;
    jump_en_o   = 1'b0;
    jump_addr_o = '0;
    hold_o      = HOLD_NONE;
    flush_o     = 1'b0;

    case (state_q)
      // The yield cycle lets the core advance exactly like a normal run cycle
      ST_RUN, ST_BUS_YIELD: begin
        state_d = ST_RUN;
        if (jump_en_i) begin
          jump_en_o   = 1'b1;
          jump_addr_o = jump_addr_i;
          flush_o     = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = ST_FLUSH;
            fcnt_d  = FCNT_LOAD;
          end
        end else if (hold_flag_i) begin
          hold_o = HOLD_ALL;
        end else if (bus_req_i) begin
          state_d = ST_BUS_HOLD;
          bcnt_d  = '0;
        end
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        fcnt_d  = fcnt_q - FCNT_W'(1);
        if (fcnt_q <= FCNT_W'(1)) begin
          state_d = ST_RUN;
          fcnt_d  = '0;
        end
      end
      ST_BUS_HOLD: begin
        hold_o = HOLD_ALL;
        if (!bus_req_i) begin
          state_d = ST_RUN;
          bcnt_d  = '0;
        end else if (bcnt_q == BCNT_LAST) begin
          state_d = ST_BUS_YIELD;
          bcnt_d  = '0;
        end else begin
          bcnt_d = bcnt_q + BCNT_W'(1);
        end
      end
      default: state_d = ST_RUN;
    endcase

    // Keep the front end quiet while reset is held
    if (!rst) begin
      jump_en_o   = 1'b0;
      jump_addr_o = '0;
      hold_o      = HOLD_NONE;
      flush_o     = 1'b0;
    end
  end

  assign bus_grant_o = grant_q;
  assign state_o     = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q, bus_cnt_q;

  // Free-running wrap-around event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      bus_cnt_q   <= '0;
    end else begin
      if (hold_o != HOLD_NONE) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (flush_o)             flush_cnt_q <= flush_cnt_q + 32'd1;
      if (grant_q)             bus_cnt_q   <= bus_cnt_q + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;
  assign bus_cnt_o   = bus_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: two configurations driven in parallel and checked against a
// cycle-level behavioural model; directed scenarios followed by random traffic.
module tb_pipe_ctrl;

  localparam int unsigned FC_A  = 1;
  localparam int unsigned BMH_A = 4;
  localparam int unsigned FC_B  = 3;
  localparam int unsigned BMH_B = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        jump_en_i;
  logic [31:0] jump_addr_i;
  logic        hold_flag_i;
  logic        bus_req_i;

  logic        je_a, fl_a, gr_a, je_b, fl_b, gr_b;
  logic [31:0] ad_a, ad_b;
  logic [1:0]  ho_a, st_a, ho_b, st_b;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] sc_a, fc_a, bc_a, sc_b, fc_b, bc_b;
`endif

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(FC_A), .BUS_MAX_HOLD(BMH_A)) dut_a (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .bus_req_i(bus_req_i), .jump_en_o(je_a),
    .jump_addr_o(ad_a), .hold_o(ho_a), .flush_o(fl_a), .bus_grant_o(gr_a),
    .state_o(st_a)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(sc_a), .flush_cnt_o(fc_a), .bus_cnt_o(bc_a)
`endif
  );

  pipe_ctrl #(.FLUSH_CYCLES(FC_B), .BUS_MAX_HOLD(BMH_B)) dut_b (
    .clk(clk), .rst(rst), .jump_en_i(jump_en_i), .jump_addr_i(jump_addr_i),
    .hold_flag_i(hold_flag_i), .bus_req_i(bus_req_i), .jump_en_o(je_b),
    .jump_addr_o(ad_b), .hold_o(ho_b), .flush_o(fl_b), .bus_grant_o(gr_b),
    .state_o(st_b)
`ifdef PIPE_CTRL_PERF_EN
    , .stall_cnt_o(sc_b), .flush_cnt_o(fc_b), .bus_cnt_o(bc_b)
`endif
  );

  // Model: remaining flush cycles, whether the bus is lent out and for how long,
  // and whether the previous cycle ended a tenure by forced yield.
  typedef struct packed {
    int flush_left;
    bit granted;
    int tenure;
    bit yielded;
  } mdl_t;

  typedef struct packed {
    logic        je;
    logic [31:0] addr;
    logic [1:0]  hold;
    logic        flush;
    logic        grant;
    logic [1:0]  st;
  } exp_t;

  int   checks = 0;
  int   errors = 0;
  mdl_t ma, mb;
  logic       last_grant_a;
  logic [1:0] last_hold_a;
  logic       last_je_a;

  function automatic exp_t predict(mdl_t m, bit in_reset, bit j, logic [31:0] a, bit h);
    exp_t e;
    e = '0;
    if (in_reset) return e;
    if (m.granted) begin
      e.hold = 2'd3; e.grant = 1'b1; e.st = 2'd2;
    end else if (m.flush_left > 0) begin
      e.flush = 1'b1; e.st = 2'd1;
    end else begin
      e.st = m.yielded ? 2'd3 : 2'd0;
      if (j) begin
        e.je = 1'b1; e.addr = a; e.flush = 1'b1;
      end else if (h) begin
        e.hold = 2'd3;
      end
    end
    return e;
  endfunction

  function automatic mdl_t advance(mdl_t m, int fc, int bmh, bit j, bit h, bit r);
    mdl_t n;
    n = m;
    n.yielded = 1'b0;
    if (m.granted) begin
      if (!r) begin
        n.granted = 1'b0; n.tenure = 0;
      end else if (m.tenure + 1 == bmh) begin
        n.granted = 1'b0; n.tenure = 0; n.yielded = 1'b1;
      end else begin
        n.tenure = m.tenure + 1;
      end
    end else if (m.flush_left > 0) begin
      n.flush_left = m.flush_left - 1;
    end else if (j) begin
      n.flush_left = fc - 1;
    end else if (!h && r) begin
      n.granted = 1'b1; n.tenure = 0;
    end
    return n;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r_n, input bit j, input logic [31:0] a, input bit h, input bit r);
    exp_t ea, eb;
    @(negedge clk);
    rst = r_n; jump_en_i = j; jump_addr_i = a; hold_flag_i = h; bus_req_i = r;
    if (!r_n) begin ma = '0; mb = '0; end
    #1;
    ea = predict(ma, !r_n, j, a, h);
    eb = predict(mb, !r_n, j, a, h);
    chk("a.jump_en",   32'(je_a), 32'(ea.je));
    chk("a.jump_addr", ad_a,      ea.addr);
    chk("a.hold",      32'(ho_a), 32'(ea.hold));
    chk("a.flush",     32'(fl_a), 32'(ea.flush));
    chk("a.grant",     32'(gr_a), 32'(ea.grant));
    chk("a.state",     32'(st_a), 32'(ea.st));
    chk("b.jump_en",   32'(je_b), 32'(eb.je));
    chk("b.jump_addr", ad_b,      eb.addr);
    chk("b.hold",      32'(ho_b), 32'(eb.hold));
    chk("b.flush",     32'(fl_b), 32'(eb.flush));
    chk("b.grant",     32'(gr_b), 32'(eb.grant));
    chk("b.state",     32'(st_b), 32'(eb.st));
    last_grant_a = gr_a;
    last_hold_a  = ho_a;
    last_je_a    = je_a;
    @(posedge clk);
    if (r_n) begin
      ma = advance(ma, FC_A, BMH_A, j, h, r);
      mb = advance(mb, FC_B, BMH_B, j, h, r);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
  endtask

  logic [11:0] grant_pat;
  logic [11:0] grant_exp;
  logic [9:0]  hold_seq;
  logic [9:0]  hold_exp;
  bit          rj, rh, rr;

  initial begin
    ma = '0; mb = '0;
    rst = 1'b0; jump_en_i = 1'b0; jump_addr_i = '0; hold_flag_i = 1'b0; bus_req_i = 1'b0;
    grant_exp = 12'b0111_1011_1101;
    hold_exp  = {2'd3, 2'd3, 2'd0, 2'd3, 2'd3};

    // Reset state, then release
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 32'h55, 1'b1, 1'b1);
    idle(2);

    // Single-cycle jump (a: stays RUN; b: three flush cycles), then a jump during flush
    step(1'b1, 1'b1, 32'h100, 1'b0, 1'b0);
    step(1'b1, 1'b1, 32'h200, 1'b0, 1'b0);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    idle(3);

    // hold_flag for five cycles with a jump in the third
    for (int i = 0; i < 5; i++) begin
      step(1'b1, i == 2, 32'h340, 1'b1, 1'b0);
      hold_seq[2*(4-i) +: 2] = last_hold_a;
      if (i == 2) chk("a.hold_jump_je", 32'(last_je_a), 32'd1);
    end
    chk("a.hold_sequence", 32'(hold_seq), 32'(hold_exp));
    idle(3);

    // Bus request held 12 cycles: forced yield every BMH_A cycles on a
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
      grant_pat[11-i] = last_grant_a;
    end
    chk("a.grant_pattern", 32'(grant_pat), 32'(grant_exp));
    idle(4);

    // Bus request rising with a jump: jump first, then grant
    step(1'b1, 1'b1, 32'h800, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(3);

    // Asynchronous reset in the middle of a bus tenure
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("a.async_grant", 32'(gr_a), 32'd0);
    chk("a.async_hold",  32'(ho_a), 32'd0);
    chk("a.async_state", 32'(st_a), 32'd0);
    chk("b.async_grant", 32'(gr_b), 32'd0);
    chk("b.async_hold",  32'(ho_b), 32'd0);
    chk("b.async_state", 32'(st_b), 32'd0);
    ma = '0; mb = '0;
    step(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1);

    // Random traffic with sticky bus requests
    rr = 1'b0;
    for (int i = 0; i < 600; i++) begin
      rj = ($urandom_range(0, 7) == 0);
      rh = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 9) == 0) rr = ~rr;
      step(($urandom_range(0, 299) != 0), rj, $urandom, rh, rr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
